// File: rtl/pipe_pkg.sv
// +--------------------------------------------------------------------------+
// | pipe_pkg                                                                 |
// | Shared state encodings and reset-fill helper for the pipeline skid stage.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

  // Bit idx of a 32-bit pattern repeated across an arbitrarily wide payload.
  function automatic logic fill_bit(input logic [31:0] pattern, input int unsigned idx);
    logic [4:0] sel;
    sel = idx[4:0];
    return pattern[sel];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_data_reg.sv
// +--------------------------------------------------------------------------+
// | pipe_data_reg                                                            |
// | DATA_W enable register, async reset, synchronous clear to RST_VAL.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_data_reg #(
  parameter int unsigned         DATA_W  = 32,
  parameter logic [DATA_W-1:0]   RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RST_VAL;
    end else if (clr_i) begin
      data_q <= RST_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// +--------------------------------------------------------------------------+
// | pipe_skid_reg                                                            |
// | Valid/ready pipeline stage register with 2-entry skid buffer.            |
// | Optional macro PIPE_ZERO_PAYLOAD_EN: invalidated payloads -> RESET_VAL.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  function automatic logic [DATA_W-1:0] f_reset_fill();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      v[i] = fill_bit(RESET_VAL, i);
    end
    return v;
  endfunction

  localparam logic [DATA_W-1:0] C_RST_VAL = f_reset_fill();

`ifdef PIPE_ZERO_PAYLOAD_EN
  localparam logic C_ZERO_PAYLOAD = 1'b1;
`else
  localparam logic C_ZERO_PAYLOAD = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              main_valid, skid_valid;
  logic              push, pop;
  logic              main_load, main_from_skid, main_clr;
  logic              skid_load, skid_clr;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign skid_valid = (state_q == ST_FULL);

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = !skid_valid && !reset;
  assign out_valid = main_valid;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  assign push = in_valid && in_ready;
  assign pop  = main_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = C_ZERO_PAYLOAD;
      skid_clr = C_ZERO_PAYLOAD;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d  = ST_EMPTY;
            main_clr = C_ZERO_PAYLOAD;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d        = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = C_ZERO_PAYLOAD;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_data_q : in_data;

  pipe_data_reg #(
    .DATA_W  (DATA_W),
    .RST_VAL (C_RST_VAL)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .en_i  (main_load),
    .clr_i (main_clr),
    .d_i   (main_d),
    .q_o   (main_data_q)
  );

  pipe_data_reg #(
    .DATA_W  (DATA_W),
    .RST_VAL (C_RST_VAL)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .en_i  (skid_load),
    .clr_i (skid_clr),
    .d_i   (in_data),
    .q_o   (skid_data_q)
  );

  assign out_data = main_data_q;

`ifndef SYNTHESIS
  a_skid_implies_main: assert property (@(posedge clk) disable iff (reset)
    skid_valid |-> main_valid);
  a_legal_state: assert property (@(posedge clk) disable iff (reset)
    state_q != 2'd3);
`endif

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It replaces fixed-field stage registers with stall/clear inputs. Upstream stalls become backpressure rather than forced bubbles. Flush empties the stage; payload is a flat vector that the instantiating stage packs from its fields (instr, PC4, PC8, RS, RT, ext, A3, ...). It sits between any two pipeline stages: F/D, D/E, E/M or M/W.

Parameters:
DATA_W, 32, payload width in bits; legal range is 1 or more (for example 197 for a D/E payload).
RESET_VAL, 0, payload reset value, replicated/truncated to DATA_W.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
flush  in  1  synchronous clear of both entries; highest priority after reset
in_valid  in  1  upstream item present
in_ready  out  1  stage can accept; equals !skid_valid && !reset
in_data  in  DATA_W  upstream payload
out_valid  out  1  main entry holds a valid item
out_ready  in  1  downstream accepts
out_data  out  DATA_W  main entry payload
occupancy  out  2  number of valid entries, 0..2

Behaviour:
- Internal state: main_valid/main_data, skid_valid/skid_data. States are EMPTY (0 entries), ONE (main only) and FULL (main and skid).
- Reset (asynchronous):
  - main_valid=0, skid_valid=0, both payloads=RESET_VAL.
  - Outputs: out_valid=0, occupancy=0, in_ready=0 while reset is high and 1 after release.
  - Reset mid-operation discards all held items.
- Transfers: push = in_valid && in_ready; pop = out_valid && out_ready.
- Transitions when flush=0:
  - EMPTY: push -> ONE (main<=in_data).
  - ONE, push && pop -> ONE (main<=in_data).
  - ONE, push && !pop -> FULL (skid<=in_data).
  - ONE, !push && pop -> EMPTY.
  - ONE, otherwise -> hold.
  - FULL (in_ready=0): pop -> ONE (main<=skid_data, skid_valid<=0); otherwise hold.
- Flush: next state is EMPTY regardless of push/pop. An item pushed in the flush cycle is dropped. A pop in the flush cycle still completes, because downstream sampled it.
- Latency and throughput:
  - Accepted item appears on out_data exactly 1 cycle later.
  - Sustained throughput is 1 item/cycle when out_ready=1.
  - in_ready is registered (no combinational path from out_ready to in_ready).
- Stability: while out_valid && !out_ready, out_data and out_valid hold unchanged until pop.
- Ordering: strict FIFO; no loss, no duplication.
- occupancy = main_valid + skid_valid.
- Invariant: skid_valid implies main_valid. A violation fires a simulation-only assertion.

Optional Feature:
PIPE_ZERO_PAYLOAD_EN.
- Defined: a payload whose entry is invalidated (pop to EMPTY, flush, skid move) is overwritten with RESET_VAL. out_data reads RESET_VAL whenever out_valid=0, giving bubble semantics identical to the old stall-clear registers (NOP instr, zero A3).
- Undefined: only the valid bits clear; payload registers keep their last value (lower toggle power). Consumers must qualify on out_valid.

Decomposition:
- Package pipe_pkg holds:
  - state localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - a helper function for the RESET_VAL fill.
- Natural sub-module: pipe_data_reg. It is a DATA_W enable register with async reset and an optional synchronous clear, instantiated twice (main, skid).

Test Plan:
1. Reset: fill to FULL, assert reset for 1/2 cycle off-edge -> out_valid=0, occupancy=0, in_ready=0 immediately; after release in_ready=1.
2. Streaming: out_ready=1, push 0x1,0x2,0x3 back-to-back -> out_data 0x1,0x2,0x3 on cycles N+1..N+3; occupancy stays 1; in_ready stays 1.
3. Backpressure: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA stable. Raise out_ready -> 0xA then 0xB delivered in order; occupancy 1 then 0.
4. Flush in FULL with in_valid=1, in_data=0xC -> next cycle occupancy=0, out_valid=0; 0xA, 0xB and 0xC never appear.
5. ONE with simultaneous push 0x5 and pop of 0x4 -> stays ONE, out_data=0x5 next cycle, occupancy=1.
6. After draining 0xB: with PIPE_ZERO_PAYLOAD_EN, out_data==RESET_VAL; without it, out_data==0xB and out_valid=0.
